mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported external memory/I-O bus (exmem plus the memory-mapped switch/LED region at addr[7:6]==2'b11) between the miniMIPS CPU (port 0) and a second bus master such as a program loader or DMA engine (port 1). It samples requests, picks one winner, issues exactly one memory transaction per grant, returns read data to the winner, and tracks fairness between the two masters. The block sits between the requesters and the memory-side mux/flop logic in the top level. Address decode is not done here; the block passes addresses through unchanged.

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported external memory / switch-LED bus
// between the miniMIPS CPU (port 0) and a second bus master (port 1).
// One memory transaction is issued per grant. Read data is returned to the
// winning port one cycle after the memory answers.
//
// Build option: define ARB_ROUND_ROBIN_EN to resolve simultaneous requests
// with an alternating priority pointer. Without it, port 0 always wins a tie
// and port 1 can starve while port 0 keeps requesting.
module mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;
  logic   owner;  // port that won the transaction in flight
  logic   pick;   // port that would win if a decision were taken this cycle

`ifdef ARB_ROUND_ROBIN_EN
  logic   ptr;    // port favoured on the next simultaneous request

  // Winner selection: a lone request wins outright, a tie goes to the pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    pick = 1'b0;
    if (req0 && req1) pick = ptr;
    else              pick = req1;
  end
`else
  // Winner selection: port 0 wins whenever it is requesting.
  always_comb begin
    pick = 1'b0;
    if (!req0 && req1) pick = 1'b1;
  end
`endif

  // Transaction sequencer: sample requests in IDLE, drive the bus in ISSUE,
  // collect read data in WAIT. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: synchronous reset clears every output register, including the
      // read-data holding registers, so a dropped read leaves no stale data.
      state    <= IDLE;
      owner    <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; the pulse outputs default
      // low here and the case below raises them for exactly one cycle.
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      mem_we  <= 1'b0;

      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner    <= pick;
            mem_addr <= pick ? addr1  : addr0;
            mem_data <= pick ? wdata1 : wdata0;
            mem_we   <= pick ? we1    : we0;
            gnt0     <= ~pick;
            gnt1     <= pick;
            busy     <= 1'b1;
            state    <= ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
            ptr      <= ~pick;
`endif
          end
        end

        ISSUE: begin
          // mem_we still holds the registered direction of this transaction.
          if (mem_we) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (owner) begin
            rdata1  <= mem_q;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= mem_q;
            rvalid0 <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, compared cycle by cycle against a transaction-level reference that
// schedules grant / read-return / idle times from the arbiter's timing rules.
// Works with or without ARB_ROUND_ROBIN_EN defined.
module tb_mem_arbiter;

  localparam int DW = 8;
  localparam int AW = 8;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic [DW-1:0] mem_q;
  logic          busy;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_q(mem_q), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Master-side transaction queues; head is the request currently presented.
  txn_t q0[$];
  txn_t q1[$];
  bit   rand_on = 1'b0;
  bit   mute0 = 1'b0, mute1 = 1'b0;

  // Reference model: scheduled event cycles and expected values.
  int            gnt_at  = -1;  // cycle in which the current grant is visible
  int            free_at = 0;   // first cycle in which requests are sampled again
  int            rv_at   = -1;  // cycle of the pending read return
  int            win     = 0;
  int            rv_port = 0;
  int            last_win = -1; // most recent winner since reset, -1 = none
  logic          t_we = 1'b0;
  logic [DW-1:0] rv_data = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] exp_rdata [2];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] dev_mem [256];

  // Memory device: answers one cycle after the address is issued; any other
  // cycle it returns noise so mistimed captures are visible.
  always @(posedge clk) begin
    if (mem_we) dev_mem[mem_addr] <= mem_data;
    mem_q <= (cyc == gnt_at) ? dev_mem[mem_addr] : DW'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset(input int next_cyc);
    gnt_at   = -1;
    rv_at    = -1;
    free_at  = next_cyc;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    m_addr   = '0;
    m_data   = '0;
    last_win = -1;
  endtask

  task automatic check_cycle();
    if (cyc == rv_at) exp_rdata[rv_port] = rv_data;
    check("gnt0",     32'(gnt0),     32'(cyc == gnt_at && win == 0));
    check("gnt1",     32'(gnt1),     32'(cyc == gnt_at && win == 1));
    check("rvalid0",  32'(rvalid0),  32'(cyc == rv_at && rv_port == 0));
    check("rvalid1",  32'(rvalid1),  32'(cyc == rv_at && rv_port == 1));
    check("rdata0",   32'(rdata0),   32'(exp_rdata[0]));
    check("rdata1",   32'(rdata1),   32'(exp_rdata[1]));
    check("mem_we",   32'(mem_we),   32'(cyc == gnt_at && t_we));
    check("mem_addr", 32'(mem_addr), 32'(m_addr));
    check("mem_data", 32'(mem_data), 32'(m_data));
    check("busy",     32'(busy),     32'(cyc >= gnt_at && cyc < free_at));
    check("gnt_both", 32'(gnt0 & gnt1), 32'(0));
  endtask

  // Masters hold their request until they see their grant, then move on.
  task automatic drive();
    if (cyc == gnt_at) begin
      if (win == 0) void'(q0.pop_front());
      else          void'(q1.pop_front());
    end
    mute0 = rand_on && ($urandom % 8 == 0);
    mute1 = rand_on && ($urandom % 8 == 0);
    if (q0.size() > 0) begin
      we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata;
    end
    if (q1.size() > 0) begin
      we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata;
    end
    req0 = (q0.size() > 0) && !mute0;
    req1 = (q1.size() > 0) && !mute1;
  endtask

  // Reference decision for the inputs of this cycle.
  task automatic decide();
    int w;
    if (reset) begin
      model_reset(cyc + 1);
    end else if (cyc >= free_at && (req0 || req1)) begin
      if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
        w = (last_win == 0) ? 1 : 0;
`else
        w = 0;
`endif
      end else begin
        w = req1 ? 1 : 0;
      end
      win      = w;
      last_win = w;
      gnt_at   = cyc + 1;
      t_we     = (w == 1) ? we1 : we0;
      m_addr   = (w == 1) ? addr1 : addr0;
      m_data   = (w == 1) ? wdata1 : wdata0;
      if (t_we) begin
        ref_mem[m_addr] = m_data;
        free_at = cyc + 2;
      end else begin
        rv_at   = cyc + 3;
        rv_port = w;
        rv_data = ref_mem[m_addr];
        free_at = cyc + 3;
      end
    end
  endtask

  task automatic step();
    check_cycle();
    drive();
    decide();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input int port, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    if (port == 0) q0.push_back(t);
    else           q1.push_back(t);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || cyc < free_at) && n < budget) begin
      step();
      n++;
    end
    check("drain_left", 32'(q0.size() + q1.size()), 32'(0));
    repeat (2) step();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom % 2 == 0) return AW'($urandom % 32);
    return AW'(8'hC0 + ($urandom % 4));
  endfunction

  initial begin
    int n;
    logic [DW-1:0] v;
    for (int i = 0; i < 256; i++) begin
      v = DW'($urandom);
      ref_mem[i] = v;
      dev_mem[i] = v;
    end
    ref_mem[8'h10] = 8'hA5;
    dev_mem[8'h10] = 8'hA5;

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc = 0;
    model_reset(0);
    reset = 1'b0;

    // Port 0 read of 0x10 returning 0xA5.
    push(0, 1'b0, 8'h10, 8'h00);
    drain(20);

    // Port 1 write 0x3C to the switch/LED region.
    push(1, 1'b1, 8'hC0, 8'h3C);
    drain(20);

    // Both ports holding reads: alternation or fixed priority by build.
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, AW'(8'h10 + i), 8'h00);
      push(1, 1'b0, AW'(8'h18 + i), 8'h00);
    end
    drain(60);

    // Reset during the WAIT cycle of a port-0 read.
    push(0, 1'b0, 8'h05, 8'h00);
    n = 0;
    while (!(cyc == gnt_at + 1 && gnt_at >= 0) && n < 10) begin
      step();
      n++;
    end
    check("reach_wait", 32'(busy && !gnt0), 32'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_rdata0", 32'(rdata0), 32'(0));
    // Pointer must be back at port 0: a tie now goes to port 0.
    push(0, 1'b0, 8'h11, 8'h00);
    push(1, 1'b0, 8'h12, 8'h00);
    drain(30);

    // Back-to-back write then read of 0x20.
    push(0, 1'b1, 8'h20, 8'h77);
    push(0, 1'b0, 8'h20, 8'h00);
    drain(20);

    // Random traffic with request gaps, withdrawals and occasional resets.
    rand_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (q0.size() == 0 && $urandom % 3 == 0)
        push(0, 1'($urandom), rand_addr(), DW'($urandom));
      if (q1.size() == 0 && $urandom % 3 == 0)
        push(1, 1'($urandom), rand_addr(), DW'($urandom));
      reset = ($urandom % 256 == 0);
      step();
      reset = 1'b0;
    end
    rand_on = 1'b0;
    drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
